// File: rtl/trng_harvest_ctrl_if.sv
// Peripheral register bus between the TinyQV core and the TRNG harvest controller.
interface trng_harvest_ctrl_if;
   logic [3:0] address;
   logic       data_write;
   logic [7:0] data_in;
   logic       data_read;
   logic [7:0] data_out;
   logic       data_ready;

   modport master (output address, data_write, data_in, data_read,
                   input  data_out, data_ready);
   modport slave  (input  address, data_write, data_in, data_read,
                   output data_out, data_ready);
endinterface

// File: rtl/trng_harvest_ctrl.sv
// Ring-oscillator TRNG controller: RO gating, warm-up, sampling with optional
// von Neumann debiasing, repetition-count health test and a byte FIFO read-out.
module trng_harvest_ctrl #(
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned WARMUP_CYCLES = 256,
   parameter int unsigned RCT_LIMIT     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  raw_bit,
   output logic                  ro_en,
   trng_harvest_ctrl_if.slave    bus
);
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam int unsigned WW = $clog2(WARMUP_CYCLES + 1);
   localparam int unsigned RW = $clog2(RCT_LIMIT + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WARMUP = 2'd1,
      S_RUN    = 2'd2,
      S_FAULT  = 2'd3
   } state_t;

   state_t        state;
   logic          enable, debias, overflow, health_fail;
   logic [7:0]    div_reg, div_cnt;
   logic [WW-1:0] warm_cnt;
   logic [RW-1:0] run_len;
   logic          prev_bit, pair_have, pair_a;
   logic [6:0]    sreg;
   logic [2:0]    bit_cnt;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;

   logic          ctrl_wr, div_wr, clr, en_nxt, tick, rct_fail, sample;
   logic          acc, acc_bit, push, push_ok, pop, empty, full;
   logic [RW-1:0] run_nxt;
   logic [7:0]    push_byte, rdata;

   // Sampling, debias and FIFO handshake decisions for this edge
   always_comb begin
      ctrl_wr   = bus.data_write && (bus.address == 4'h0);
      div_wr    = bus.data_write && (bus.address == 4'h1);
      clr       = ctrl_wr && bus.data_in[2];
      en_nxt    = ctrl_wr ? bus.data_in[0] : enable;
      tick      = (state == S_RUN) && (div_cnt == 8'd0) && en_nxt && !clr;
      run_nxt   = ((run_len != '0) && (raw_bit == prev_bit)) ? run_len + RW'(1) : RW'(1);
      rct_fail  = tick && (run_nxt == RW'(RCT_LIMIT));
      sample    = tick && !rct_fail;
      acc       = 1'b0;
      acc_bit   = raw_bit;
      if (sample) begin
         if (!debias) begin
            acc = 1'b1;
         end else if (pair_have && (pair_a != raw_bit)) begin
            acc     = 1'b1;
            acc_bit = pair_a;
         end
      end
      push      = acc && (bit_cnt == 3'd7);
      push_byte = {sreg, acc_bit};
      empty     = (count == '0);
      full      = (count == CW'(FIFO_DEPTH));
      pop       = bus.data_read && (bus.address == 4'h3) && !empty;
      push_ok   = push && (!full || pop);
   end

   always_comb begin
      rdata = 8'h00;
      case (bus.address)
         4'h0:    rdata = {6'b0, debias, enable};
         4'h1:    rdata = div_reg;
         4'h2:    rdata = {2'b00, state, overflow, health_fail, full, !empty};
         4'h3:    rdata = empty ? 8'h00 : mem[rd_ptr];
         4'h4:    rdata = 8'(count);
         default: rdata = 8'h00;
      endcase
   end

   assign bus.data_out   = rdata;
   assign bus.data_ready = !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         ro_en       <= 1'b0;
         enable      <= 1'b0;
         debias      <= 1'b0;
         overflow    <= 1'b0;
         health_fail <= 1'b0;
         div_reg     <= 8'h00;
         div_cnt     <= 8'h00;
         warm_cnt    <= '0;
         run_len     <= '0;
         prev_bit    <= 1'b0;
         pair_have   <= 1'b0;
         pair_a      <= 1'b0;
         sreg        <= '0;
         bit_cnt     <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= 8'h00;
      end else begin
         if (ctrl_wr) begin
            enable <= bus.data_in[0];
            debias <= bus.data_in[1];
         end
         if (div_wr) div_reg <= bus.data_in;

         if (clr) begin
            state       <= S_IDLE;
            ro_en       <= 1'b0;
            health_fail <= 1'b0;
            overflow    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            bit_cnt     <= '0;
            sreg        <= '0;
            pair_have   <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (en_nxt) begin
                     state    <= S_WARMUP;
                     ro_en    <= 1'b1;
                     warm_cnt <= '0;
                  end
               end
               S_WARMUP, S_RUN: begin
                  if (!en_nxt) begin
                     // Partial byte is dropped; queued bytes stay readable
                     state     <= S_IDLE;
                     ro_en     <= 1'b0;
                     bit_cnt   <= '0;
                     sreg      <= '0;
                     pair_have <= 1'b0;
                  end else if (state == S_WARMUP) begin
                     if (warm_cnt == WW'(WARMUP_CYCLES - 1)) begin
                        state     <= S_RUN;
                        div_cnt   <= 8'h00;
                        run_len   <= '0;
                        pair_have <= 1'b0;
                        bit_cnt   <= '0;
                        sreg      <= '0;
                     end else begin
                        warm_cnt <= warm_cnt + WW'(1);
                     end
                  end else if (rct_fail) begin
                     state       <= S_FAULT;
                     ro_en       <= 1'b0;
                     health_fail <= 1'b1;
                  end else if (tick) begin
                     div_cnt  <= div_reg;
                     prev_bit <= raw_bit;
                     run_len  <= run_nxt;
                  end else begin
                     div_cnt <= div_cnt - 8'd1;
                  end
               end
               default: ;
            endcase

            if (sample && debias) begin
               pair_have <= !pair_have;
               pair_a    <= raw_bit;
            end
            if (acc) begin
               sreg    <= push_byte[6:0];
               bit_cnt <= bit_cnt + 3'd1;
            end

            // Byte FIFO; a pop frees the slot a same-cycle push needs
            if (push_ok) begin
               mem[wr_ptr] <= push_byte;
               wr_ptr      <= wr_ptr + PW'(1);
            end
            if (push && !push_ok) overflow <= 1'b1;
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push_ok) - CW'(pop);
         end
      end
   end
endmodule

// File: tb/tb_trng_harvest_ctrl.sv
// Directed bench for trng_harvest_ctrl with a queue-based reference model
// checked every cycle plus literal expectations for each scenario.
module tb_trng_harvest_ctrl;
   localparam int WARM  = 16;
   localparam int LIM   = 32;
   localparam int DEPTH = 4;

   logic clk, rst, raw_bit, ro_en;
   trng_harvest_ctrl_if bus ();

   trng_harvest_ctrl #(.FIFO_DEPTH(DEPTH), .WARMUP_CYCLES(WARM), .RCT_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst), .raw_bit(raw_bit), .ro_en(ro_en), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h want %02h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 warm-up, 2 run, 3 fault
   int         m_phase, m_warm, m_divcnt, m_run;
   bit         m_en, m_deb, m_hf, m_ovf, m_prev;
   logic [7:0] m_div;
   bit         m_bits[$];
   bit         m_pair[$];
   logic [7:0] m_fifo[$];

   task automatic model_step();
      bit wc, clr, en_n, do_pop, have_push, s;
      logic [7:0] pb;
      if (rst) begin
         m_phase = 0; m_warm = 0; m_divcnt = 0; m_run = 0;
         m_en = 0; m_deb = 0; m_hf = 0; m_ovf = 0; m_prev = 0; m_div = 8'h00;
         m_bits.delete(); m_pair.delete(); m_fifo.delete();
         return;
      end
      wc        = bus.data_write && (bus.address == 4'h0);
      clr       = wc && bus.data_in[2];
      en_n      = wc ? bus.data_in[0] : m_en;
      do_pop    = bus.data_read && (bus.address == 4'h3) && (m_fifo.size() > 0);
      have_push = 0;
      pb        = 8'h00;
      if (clr) begin
         m_phase = 0; m_hf = 0; m_ovf = 0; do_pop = 0;
         m_fifo.delete(); m_bits.delete(); m_pair.delete();
      end else if (m_phase != 3 && !en_n) begin
         m_phase = 0;
         m_bits.delete(); m_pair.delete();
      end else if (m_phase == 0) begin
         m_phase = 1; m_warm = 0;
      end else if (m_phase == 1) begin
         m_warm++;
         if (m_warm == WARM) begin
            m_phase = 2; m_divcnt = 0; m_run = 0;
            m_bits.delete(); m_pair.delete();
         end
      end else if (m_phase == 2) begin
         if (m_divcnt == 0) begin
            s = raw_bit;
            m_run = (m_run > 0 && s == m_prev) ? m_run + 1 : 1;
            m_prev = s;
            m_divcnt = int'(m_div);
            if (m_run >= LIM) begin
               m_phase = 3; m_hf = 1;
            end else begin
               if (!m_deb) m_bits.push_back(s);
               else begin
                  m_pair.push_back(s);
                  if (m_pair.size() == 2) begin
                     if (m_pair[0] != m_pair[1]) m_bits.push_back(m_pair[0]);
                     m_pair.delete();
                  end
               end
               if (m_bits.size() == 8) begin
                  foreach (m_bits[i]) pb[7-i] = m_bits[i];
                  have_push = 1;
                  m_bits.delete();
               end
            end
         end else begin
            m_divcnt--;
         end
      end
      if (do_pop) void'(m_fifo.pop_front());
      if (have_push) begin
         if (m_fifo.size() < DEPTH) m_fifo.push_back(pb);
         else m_ovf = 1;
      end
      if (wc) begin
         m_en  = bus.data_in[0];
         m_deb = bus.data_in[1];
      end
      if (bus.data_write && bus.address == 4'h1) m_div = bus.data_in;
   endtask

   function automatic logic [7:0] m_read(input logic [3:0] a);
      logic [7:0] r;
      r = 8'h00;
      case (a)
         4'h0: r = {6'b0, m_deb, m_en};
         4'h1: r = m_div;
         4'h2: r = {2'b00, 2'(m_phase), m_ovf, m_hf, m_fifo.size() == DEPTH, m_fifo.size() != 0};
         4'h3: r = (m_fifo.size() != 0) ? m_fifo[0] : 8'h00;
         4'h4: r = 8'(m_fifo.size());
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   // Per-cycle comparison against the model, well after the edge has settled
   initial forever begin
      @(posedge clk);
      #2;
      if (chk_on) begin
         chk("ro_en", 8'(ro_en), 8'((m_phase == 1) || (m_phase == 2)));
         chk("data_ready", 8'(bus.data_ready), 8'(m_fifo.size() != 0));
         chk("data_out", bus.data_out, m_read(bus.address));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "bench did not terminate");
   end

   bit stim[$];

   task automatic add_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) stim.push_back(b[i]);
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      bus.address = a; bus.data_in = d; bus.data_write = 1'b1;
      @(negedge clk);
      bus.data_write = 1'b0;
   endtask

   task automatic pop1();
      bus.address = 4'h3; bus.data_read = 1'b1;
      @(negedge clk);
      bus.data_read = 1'b0;
   endtask

   task automatic peek(input string nm, input logic [3:0] a, input logic [7:0] exp);
      bus.address = a;
      #1;
      chk(nm, bus.data_out, exp);
   endtask

   // Enable, wait out warm-up, drive one raw bit per cycle, then disable
   task automatic run_stim(input logic [7:0] ctrl, input bit pop_last, input bit keep_on,
                           input logic [7:0] old_head);
      wr(4'h0, ctrl);
      chk("ro_en_after_enable", 8'(ro_en), 8'h01);
      repeat (WARM) @(negedge clk);
      foreach (stim[i]) begin
         raw_bit = stim[i];
         if (pop_last && i == stim.size() - 1) begin
            bus.address = 4'h3; bus.data_read = 1'b1;
            #1;
            chk("pop_push_old_head", bus.data_out, old_head);
         end
         @(negedge clk);
         bus.data_read = 1'b0;
      end
      if (!keep_on) wr(4'h0, ctrl & 8'hFE);
   endtask

   initial begin
      rst = 1'b1; raw_bit = 1'b0;
      bus.address = 4'h0; bus.data_write = 1'b0; bus.data_in = 8'h00; bus.data_read = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_ro_en", 8'(ro_en), 8'h00);
      chk("reset_ready", 8'(bus.data_ready), 8'h00);
      peek("reset_status", 4'h2, 8'h00);
      peek("reset_data", 4'h3, 8'h00);
      peek("reset_level", 4'h4, 8'h00);
      @(negedge clk);
      chk_on = 1'b1;

      // Plain sampling, DIV=0
      stim.delete();
      for (int i = 0; i < 8; i++) stim.push_back(bit'((i % 2) == 0));
      run_stim(8'h01, 1'b0, 1'b0, 8'h00);
      peek("aa_data", 4'h3, 8'hAA);
      peek("aa_level", 4'h4, 8'h01);
      chk("aa_ready", 8'(bus.data_ready), 8'h01);
      @(negedge clk);
      pop1();
      peek("aa_level_after_pop", 4'h4, 8'h00);
      chk("aa_ready_after_pop", 8'(bus.data_ready), 8'h00);
      @(negedge clk);

      // Von Neumann: 10,01,11,00,10,10,01,10,01,10 -> 1,0,1,1,0,1,0,1
      stim = '{1,0, 0,1, 1,1, 0,0, 1,0, 1,0, 0,1, 1,0, 0,1, 1,0};
      run_stim(8'h03, 1'b0, 1'b0, 8'h00);
      peek("vn_data", 4'h3, 8'hB5);
      peek("vn_level", 4'h4, 8'h01);
      @(negedge clk);
      pop1();

      // DIV=2: only every third cycle's raw bit counts
      wr(4'h1, 8'h02);
      stim.delete();
      for (int k = 7; k >= 0; k--) begin
         logic [7:0] v;
         v = 8'h5C;
         stim.push_back(v[k]);
         stim.push_back(!v[k]);
         stim.push_back(!v[k]);
      end
      run_stim(8'h01, 1'b0, 1'b0, 8'h00);
      peek("div_data", 4'h3, 8'h5C);
      peek("div_level", 4'h4, 8'h01);
      @(negedge clk);
      pop1();
      wr(4'h1, 8'h00);

      // Stuck-at-1 source trips the repetition-count test
      stim.delete();
      for (int i = 0; i < 40; i++) stim.push_back(1'b1);
      run_stim(8'h01, 1'b0, 1'b1, 8'h00);
      peek("rct_status", 4'h2, 8'h35);
      peek("rct_level", 4'h4, 8'h03);
      peek("rct_data", 4'h3, 8'hFF);
      chk("rct_ro_en", 8'(ro_en), 8'h00);
      @(negedge clk);
      raw_bit = 1'b0;
      wr(4'h0, 8'h05);
      peek("clear_status", 4'h2, 8'h00);
      @(negedge clk);
      peek("clear_rewarm", 4'h2, 8'h10);
      @(negedge clk);
      wr(4'h0, 8'h04);

      // Five bytes into a four-entry FIFO with no reads
      stim.delete();
      add_byte(8'h12); add_byte(8'h34); add_byte(8'h56); add_byte(8'h78); add_byte(8'h9A);
      run_stim(8'h01, 1'b0, 1'b0, 8'h00);
      peek("ovf_level", 4'h4, 8'h04);
      peek("ovf_status", 4'h2, 8'h0B);
      @(negedge clk);
      begin
         logic [7:0] exp_q[4];
         exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
         foreach (exp_q[i]) begin
            peek("ovf_drain", 4'h3, exp_q[i]);
            pop1();
         end
      end
      peek("ovf_empty_data", 4'h3, 8'h00);
      pop1();
      peek("ovf_empty_level", 4'h4, 8'h00);
      @(negedge clk);

      // Pop coinciding with a push into a full FIFO
      wr(4'h0, 8'h04);
      peek("pp_status0", 4'h2, 8'h00);
      @(negedge clk);
      stim.delete();
      add_byte(8'h21); add_byte(8'h43); add_byte(8'h65); add_byte(8'h87); add_byte(8'hA9);
      run_stim(8'h01, 1'b1, 1'b0, 8'h21);
      peek("pp_level", 4'h4, 8'h04);
      peek("pp_status", 4'h2, 8'h03);
      @(negedge clk);
      begin
         logic [7:0] exp_q[4];
         exp_q = '{8'h43, 8'h65, 8'h87, 8'hA9};
         foreach (exp_q[i]) begin
            peek("pp_drain", 4'h3, exp_q[i]);
            pop1();
         end
      end

      // Asynchronous reset in the middle of RUN with two bytes queued
      stim.delete();
      add_byte(8'hC3); add_byte(8'h3C);
      run_stim(8'h01, 1'b0, 1'b1, 8'h00);
      peek("mid_level", 4'h4, 8'h02);
      rst = 1'b1;
      #1;
      chk("mid_rst_ro_en", 8'(ro_en), 8'h00);
      chk("mid_rst_ready", 8'(bus.data_ready), 8'h00);
      @(negedge clk);
      peek("mid_rst_status", 4'h2, 8'h00);
      peek("mid_rst_level", 4'h4, 8'h00);
      peek("mid_rst_data", 4'h3, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
